// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one barrel shifter among NUM_REQ requesters
// with a registered single-entry result slot.
module barrel_shift #(
  parameter int LENGTH = 8,
  parameter int LEFT = 1
) (
  input  logic [LENGTH-1:0]         data,
  input  logic [$clog2(LENGTH)-1:0] shamt,
  output logic [LENGTH-1:0]         result
);
  assign result = LEFT != 0 ? data << shamt : data >> shamt;
endmodule

module shift_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LENGTH = 8,
  parameter int LEFT = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*LENGTH-1:0]           req_data,
  input  logic [NUM_REQ*$clog2(LENGTH)-1:0]   req_shamt,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [LENGTH-1:0]                   resp_data,
  output logic [$clog2(NUM_REQ)-1:0]          resp_id
);
  localparam int SW = $clog2(LENGTH);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [IW-1:0] last_grant, grant_id, idx;
  logic grant, can_accept;
  logic [LENGTH-1:0] data_arr [NUM_REQ];
  logic [SW-1:0] shamt_arr [NUM_REQ];
  logic [LENGTH-1:0] shifted;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*LENGTH +: LENGTH];
    assign shamt_arr[g] = req_shamt[g*SW +: SW];
  end
  assign can_accept = rst_n && (state == EMPTY || resp_ready);
  // Scan from farthest to nearest so the nearest valid index after last_grant wins.
  always_comb begin
    grant = 1'b0;
    grant_id = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (can_accept && req_valid[idx]) begin
        grant = 1'b1;
        grant_id = idx;
      end
    end
  end
  assign req_ready = grant ? NUM_REQ'(1) << grant_id : '0;
  barrel_shift #(.LENGTH(LENGTH), .LEFT(LEFT)) u_shift (
    .data(data_arr[grant_id]),
    .shamt(shamt_arr[grant_id]),
    .result(shifted)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_id <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else if (grant) begin
      state <= FULL;
      resp_valid <= 1'b1;
      resp_data <= shifted;
      resp_id <= grant_id;
      last_grant <= grant_id;
    end else if (state == FULL && resp_ready) begin
      state <= EMPTY;
      resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed and random checks of shift_arbiter against a behavioural model
module tb_shift_arbiter;
  localparam int N = 4;
  localparam int L = 8;
  logic clk = 0, rst_n = 0, resp_ready = 0;
  logic [N-1:0] req_valid = '0;
  logic [7:0] d [N];
  logic [2:0] s [N];
  logic [N*L-1:0] req_data;
  logic [N*3-1:0] req_shamt;
  logic [N-1:0] req_ready, req_ready_r;
  logic resp_valid, resp_valid_r;
  logic [7:0] resp_data, resp_data_r;
  logic [1:0] resp_id, resp_id_r;
  int passed = 0, total = 0;
  int m_last = N - 1, m_data = 0, m_data_r = 0, m_id = 0, exp_g = -1;
  bit m_valid = 0, en = 0;

  always #5 clk = ~clk;
  assign req_data = {d[3], d[2], d[1], d[0]};
  assign req_shamt = {s[3], s[2], s[1], s[0]};

  shift_arbiter #(.NUM_REQ(N), .LENGTH(L), .LEFT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_shamt(req_shamt), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id)
  );
  shift_arbiter #(.NUM_REQ(N), .LENGTH(L), .LEFT(0)) dut_r (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_shamt(req_shamt), .req_ready(req_ready_r), .resp_valid(resp_valid_r),
    .resp_ready(resp_ready), .resp_data(resp_data_r), .resp_id(resp_id_r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int ref_shift(input int data, input int sh, input bit left);
    return left ? (data * (2 ** sh)) % 256 : data / (2 ** sh);
  endfunction

  function automatic int model_grant();
    if (!rst_n || (m_valid && !resp_ready)) return -1;
    for (int k = 1; k <= N; k++)
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    int g;
    g = model_grant();
    exp_g <= g;
    if (en) begin
      check("req_ready", req_ready, g < 0 ? 0 : 1 << g);
      check("req_ready_r", req_ready_r, g < 0 ? 0 : 1 << g);
      check("resp_valid", resp_valid, m_valid);
      check("resp_id", resp_id, m_id);
      check("resp_data", resp_data, m_data);
      check("resp_data_r", resp_data_r, m_data_r);
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 0; m_data <= 0; m_data_r <= 0; m_id <= 0; m_last <= N - 1;
    end else if (exp_g >= 0) begin
      m_valid <= 1;
      m_data <= ref_shift(d[exp_g], s[exp_g], 1);
      m_data_r <= ref_shift(d[exp_g], s[exp_g], 0);
      m_id <= exp_g;
      m_last <= exp_g;
    end else if (m_valid && resp_ready) m_valid <= 0;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic mid();
    @(negedge clk); #1;
  endtask
  task automatic do_reset();
    tick(); rst_n = 0;
    tick(); rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin d[i] = 0; s[i] = 0; end
    req_valid = 4'hF;
    tick(); en = 1;
    tick(); mid();
    check("rst_ready", req_ready, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_id", resp_id, 0);
    // single request
    tick(); rst_n = 1; req_valid = 4'b0001; d[0] = 8'h81; s[0] = 1; resp_ready = 0;
    mid(); check("single_grant", req_ready, 4'b0001);
    tick(); req_valid = 0;
    mid(); check("single_valid", resp_valid, 1); check("single_data", resp_data, 8'h02);
    check("single_id", resp_id, 0); check("single_hold_ready", req_ready, 0);
    tick(); resp_ready = 1;
    tick(); mid(); check("single_drain", resp_valid, 0);
    // fairness, one result per cycle
    do_reset();
    for (int i = 0; i < N; i++) begin d[i] = 8'h01; s[i] = 3'(i); end
    req_valid = 4'hF;
    for (int j = 0; j < 8; j++) begin
      tick(); mid();
      check("rr_id", resp_id, j % 4);
      check("rr_data", resp_data, 1 << (j % 4));
      check("rr_ready", req_ready, 1 << ((j + 1) % 4));
    end
    // backpressure
    tick(); resp_ready = 0;
    for (int j = 0; j < 3; j++) begin
      tick(); mid();
      check("bp_ready", req_ready, 0); check("bp_id", resp_id, 0); check("bp_data", resp_data, 8'h01);
    end
    tick(); resp_ready = 1;
    mid(); check("bp_release", req_ready, 4'b0010);
    tick(); mid(); check("bp_next_id", resp_id, 1); check("bp_next_data", resp_data, 8'h02);
    // priority rotation
    do_reset(); req_valid = 4'b0100;
    mid(); check("rot_g2", req_ready, 4'b0100);
    tick(); req_valid = 4'b0101;
    mid(); check("rot_g0", req_ready, 4'b0001);
    tick(); mid(); check("rot_g2b", req_ready, 4'b0100); check("rot_id0", resp_id, 0);
    tick(); mid(); check("rot_id2", resp_id, 2); check("rot_data2", resp_data, 8'h04);
    // shift boundaries
    do_reset(); req_valid = 4'b0001; d[0] = 8'hFF; s[0] = 0;
    tick(); mid(); check("sh0_left", resp_data, 8'hFF); check("sh0_right", resp_data_r, 8'hFF);
    tick(); s[0] = 7;
    tick(); mid(); check("sh7_left", resp_data, 8'h80); check("sh7_right", resp_data_r, 8'h01);
    // reset while FULL
    do_reset(); resp_ready = 0; req_valid = 4'b1000;
    tick(); mid(); check("full_id3", resp_id, 3); check("full_valid", resp_valid, 1);
    tick(); rst_n = 0; req_valid = 4'hF;
    tick(); rst_n = 1;
    mid(); check("mrst_valid", resp_valid, 0); check("mrst_data", resp_data, 0);
    check("mrst_id", resp_id, 0); check("mrst_grant", req_ready, 4'b0001);
    tick(); mid(); check("mrst_first_id", resp_id, 0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || exp_g == i) begin
          req_valid[i] = $urandom_range(0, 2) != 0;
          d[i] = 8'($urandom);
          s[i] = 3'($urandom);
        end
      resp_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 99) != 0;
    end
    tick(); mid();
    en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
